// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode bytes from rx_uart, presents them to the ALU,
// then hands the ALU result to tx_uart as a single-byte frame.
module uart_alu_interface #(
  parameter int unsigned NB_DATA  = 8,
  parameter int unsigned NB_OP    = 6,
  parameter int unsigned NB_STATE = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_error
);

  typedef enum logic [NB_STATE-1:0] {
    StWaitA  = 3'd0,
    StWaitB  = 3'd1,
    StWaitOp = 3'd2,
    StSend   = 3'd3,
    StWaitTx = 3'd4
  } state_e;

  localparam logic [NB_OP-1:0] OpAdd = 6'b100000;
  localparam logic [NB_OP-1:0] OpSub = 6'b100010;
  localparam logic [NB_OP-1:0] OpAnd = 6'b100100;
  localparam logic [NB_OP-1:0] OpOr  = 6'b100101;
  localparam logic [NB_OP-1:0] OpXor = 6'b100110;
  localparam logic [NB_OP-1:0] OpNor = 6'b100111;
  localparam logic [NB_OP-1:0] OpSra = 6'b000011;
  localparam logic [NB_OP-1:0] OpSrl = 6'b000010;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] a_tmp_q, a_tmp_d;
  logic [NB_DATA-1:0] b_tmp_q, b_tmp_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               tx_start_q, tx_start_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;

  logic [NB_OP-1:0] rx_opcode;
  logic             opcode_valid;

  assign rx_opcode = i_rx_data[NB_OP-1:0];

  // Upper bits of the opcode byte must be clear for the byte to be accepted.
  always_comb begin
    opcode_valid = 1'b0;
    if (i_rx_data[NB_DATA-1:NB_OP] == '0) begin
      case (rx_opcode)
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSra, OpSrl: opcode_valid = 1'b1;
        default:                                               opcode_valid = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    a_tmp_d    = a_tmp_q;
    b_tmp_d    = b_tmp_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    op_d       = op_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    error_d    = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      StWaitA: begin
        if (i_rx_done_tick) begin
          a_tmp_d = i_rx_data;
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        if (i_rx_done_tick) begin
          b_tmp_d = i_rx_data;
          state_d = StWaitOp;
        end
      end
      StWaitOp: begin
        if (i_rx_done_tick) begin
          if (opcode_valid) begin
            data_a_d = a_tmp_q;
            data_b_d = b_tmp_q;
            op_d     = rx_opcode;
            state_d  = StSend;
          end else begin
            error_d = 1'b1;
            state_d = StWaitA;
          end
        end
      end
      StSend: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        error_d    = i_rx_done_tick;
        state_d    = StWaitTx;
      end
      StWaitTx: begin
        // A byte arriving together with tx_done is dropped, never reused as operand A.
        error_d = i_rx_done_tick;
        if (i_tx_done_tick) begin
          state_d = StWaitA;
        end
      end
      default: begin
        state_d = StWaitA;
      end
    endcase

    if (state_q inside {StWaitA, StWaitB, StWaitOp, StSend, StWaitTx}) begin
      busy_d = (state_d == StSend) || (state_d == StWaitTx);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StWaitA;
      a_tmp_q    <= '0;
      b_tmp_q    <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_tmp_q    <= a_tmp_d;
      b_tmp_q    <= b_tmp_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      op_q       <= op_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_op       = op_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_error    = error_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with a behavioural ALU driving i_alu_result.
module tb_uart_alu_interface;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_rx_done_tick = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic [7:0] i_alu_result;
  logic       i_tx_done_tick = 1'b0;
  logic [7:0] o_data_a;
  logic [7:0] o_data_b;
  logic [5:0] o_op;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_busy;
  logic       o_error;

  int total = 0;
  int bad   = 0;

  uart_alu_interface dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_rx_done_tick (i_rx_done_tick),
    .i_rx_data      (i_rx_data),
    .i_alu_result   (i_alu_result),
    .i_tx_done_tick (i_tx_done_tick),
    .o_data_a       (o_data_a),
    .o_data_b       (o_data_b),
    .o_op           (o_op),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .o_busy         (o_busy),
    .o_error        (o_error)
  );

  always #5 i_clock = ~i_clock;

  always_comb begin
    case (o_op)
      6'b100000: i_alu_result = o_data_a + o_data_b;
      6'b100010: i_alu_result = o_data_a - o_data_b;
      6'b100100: i_alu_result = o_data_a & o_data_b;
      6'b100101: i_alu_result = o_data_a | o_data_b;
      6'b100110: i_alu_result = o_data_a ^ o_data_b;
      6'b100111: i_alu_result = ~(o_data_a | o_data_b);
      6'b000011: i_alu_result = $unsigned($signed(o_data_a) >>> o_data_b);
      6'b000010: i_alu_result = o_data_a >> o_data_b;
      default:   i_alu_result = 8'h00;
    endcase
  end

  // Returns on the falling edge after the rising edge that sampled the byte.
  task automatic rx_byte(input logic [7:0] b);
    @(negedge i_clock);
    i_rx_data      = b;
    i_rx_done_tick = 1'b1;
    @(negedge i_clock);
    i_rx_done_tick = 1'b0;
  endtask

  task automatic tx_done_pulse();
    @(negedge i_clock);
    i_tx_done_tick = 1'b1;
    @(negedge i_clock);
    i_tx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge i_clock);
    i_reset = 1'b1;
    #1;
    total++;
    if ({o_data_a, o_data_b, o_op, o_tx_start, o_tx_data, o_busy, o_error} !== 37'd0) begin
      bad++;
      $display("FAIL reset_outputs: got a=%h b=%h op=%h st=%b txd=%h busy=%b err=%b want all 0",
               o_data_a, o_data_b, o_op, o_tx_start, o_tx_data, o_busy, o_error);
    end
    @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  task automatic test_add();
    rx_byte(8'h05);
    rx_byte(8'h03);
    rx_byte(8'h20);
    total++;
    if (o_op !== 6'h20 || o_data_a !== 8'h05 || o_data_b !== 8'h03) begin
      bad++;
      $display("FAIL add_alu_inputs: got a=%h b=%h op=%h want 05 03 20", o_data_a, o_data_b, o_op);
    end
    total++;
    if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL add_n1: got start=%b busy=%b want 0 1", o_tx_start, o_busy);
    end
    @(negedge i_clock);
    total++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h08) begin
      bad++;
      $display("FAIL add_n2: got start=%b txd=%h want 1 08", o_tx_start, o_tx_data);
    end
    @(negedge i_clock);
    total++;
    if (o_tx_start !== 1'b0 || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL add_pulse_end: got start=%b busy=%b want 0 1", o_tx_start, o_busy);
    end
    tx_done_pulse();
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL add_idle: got busy=%b want 0", o_busy);
    end
  endtask

  task automatic test_sub();
    rx_byte(8'h0F);
    rx_byte(8'h01);
    rx_byte(8'h22);
    @(negedge i_clock);
    @(negedge i_clock);
    total++;
    if (o_tx_data !== 8'h0E || o_busy !== 1'b1) begin
      bad++;
      $display("FAIL sub_result: got txd=%h busy=%b want 0e 1", o_tx_data, o_busy);
    end
    tx_done_pulse();
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL sub_busy_fall: got busy=%b want 0", o_busy);
    end
  endtask

  task automatic test_invalid_op();
    int starts = 0;
    rx_byte(8'h01);
    rx_byte(8'h02);
    rx_byte(8'h3F);
    total++;
    if (o_error !== 1'b1 || o_busy !== 1'b0 || o_op !== 6'h22 || o_data_a !== 8'h0F) begin
      bad++;
      $display("FAIL invalid_err: got err=%b busy=%b op=%h a=%h want 1 0 22 0f",
               o_error, o_busy, o_op, o_data_a);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clock);
      if (o_tx_start === 1'b1) starts++;
      if (i == 0) begin
        total++;
        if (o_error !== 1'b0) begin
          bad++;
          $display("FAIL invalid_err_width: got err=%b want 0", o_error);
        end
      end
    end
    total++;
    if (starts != 0) begin
      bad++;
      $display("FAIL invalid_no_start: got %0d starts want 0", starts);
    end
    rx_byte(8'h04);
    rx_byte(8'h04);
    rx_byte(8'h24);
    @(negedge i_clock);
    total++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h04) begin
      bad++;
      $display("FAIL invalid_then_and: got start=%b txd=%h want 1 04", o_tx_start, o_tx_data);
    end
    tx_done_pulse();
  endtask

  task automatic test_extra_rx();
    rx_byte(8'h03);
    rx_byte(8'h05);
    rx_byte(8'h20);
    @(negedge i_clock);
    rx_byte(8'hAA);
    total++;
    if (o_error !== 1'b1 || o_busy !== 1'b1 || o_tx_data !== 8'h08) begin
      bad++;
      $display("FAIL extra_rx: got err=%b busy=%b txd=%h want 1 1 08", o_error, o_busy, o_tx_data);
    end
    tx_done_pulse();
    rx_byte(8'h02);
    rx_byte(8'h03);
    rx_byte(8'h26);
    @(negedge i_clock);
    total++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h01 || o_data_a !== 8'h02) begin
      bad++;
      $display("FAIL extra_rx_next: got start=%b txd=%h a=%h want 1 01 02",
               o_tx_start, o_tx_data, o_data_a);
    end
    tx_done_pulse();
  endtask

  task automatic test_reset_mid_frame();
    rx_byte(8'h05);
    rx_byte(8'h03);
    test_reset();
    rx_byte(8'h07);
    rx_byte(8'h01);
    rx_byte(8'h25);
    @(negedge i_clock);
    total++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h07 || o_data_a !== 8'h07 || o_data_b !== 8'h01) begin
      bad++;
      $display("FAIL reset_mid_or: got start=%b txd=%h a=%h b=%h want 1 07 07 01",
               o_tx_start, o_tx_data, o_data_a, o_data_b);
    end
    tx_done_pulse();
  endtask

  task automatic test_back_to_back();
    rx_byte(8'h09);
    rx_byte(8'h02);
    rx_byte(8'h20);
    @(negedge i_clock);
    @(negedge i_clock);
    i_rx_data      = 8'h55;
    i_rx_done_tick = 1'b1;
    i_tx_done_tick = 1'b1;
    @(negedge i_clock);
    i_rx_done_tick = 1'b0;
    i_tx_done_tick = 1'b0;
    total++;
    if (o_error !== 1'b1 || o_busy !== 1'b0 || o_tx_data !== 8'h0B) begin
      bad++;
      $display("FAIL both_ticks: got err=%b busy=%b txd=%h want 1 0 0b", o_error, o_busy, o_tx_data);
    end
    rx_byte(8'h06);
    rx_byte(8'h01);
    rx_byte(8'h22);
    @(negedge i_clock);
    total++;
    if (o_tx_start !== 1'b1 || o_tx_data !== 8'h05 || o_data_a !== 8'h06) begin
      bad++;
      $display("FAIL both_ticks_next: got start=%b txd=%h a=%h want 1 05 06",
               o_tx_start, o_tx_data, o_data_a);
    end
    tx_done_pulse();
  endtask

  initial begin
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_invalid_op();
    test_extra_rx();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
